dmem_port_arbiter: RTL

- Shares the single data-memory port between two requesters: the core (port 0) and the boot/loader engine (port 1).
- Replaces the ad-hoc select mux: a round-robin arbiter with a boot-mode lock that grants only the loader.
- Tracks outstanding transactions in an in-order tag FIFO so each memory response is routed back to the requester that issued it.
- Sits between the core's to_mem/from_mem ports and data_mem.

---
 rtl/dmem_port_arbiter_if.sv | 21 ++
 rtl/dmem_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: one data-memory style channel (request, accept, response).
// On a requester port "ready" is the yumi and rvalid/rdata carry the routed response.
// On the memory port "ready" is the memory accept and rvalid/rdata the raw memory response.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              wen;
    logic              byte_nw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, wen, byte_nw, addr, wdata,
                    input  ready, rvalid, rdata);
    modport slave  (input  valid, wen, byte_nw, addr, wdata,
                    output ready, rvalid, rdata);
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the core (port 0) and the
// boot/loader engine (port 1). Round-robin grant with a boot-mode lock, and an in-order
// tag FIFO that steers each memory response back to the port that issued the request.
// Optional grant/conflict statistics are built when DMEM_PORT_ARB_STATS_EN is defined;
// otherwise the counter outputs are tied to zero.
module dmem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int OUTSTANDING_P = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     boot_mode_i,
    dmem_port_arbiter_if.slave       req0_if,
    dmem_port_arbiter_if.slave       req1_if,
    dmem_port_arbiter_if.master      mem_if,
    output logic                     error_o,
    output logic [31:0]              grant0_cnt_o,
    output logic [31:0]              grant1_cnt_o,
    output logic [31:0]              conflict_cnt_o
);
    localparam int PW = $clog2(OUTSTANDING_P);
    localparam int CW = PW + 1;

    logic          elig0, elig1, both_elig, win_any, win_id;
    logic          accept, push, pop, full, empty, tag_full_eff, head;
    logic          ptr_q, ptr_d;
    logic          error_q, error_d;
    logic [OUTSTANDING_P-1:0] tags_q;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Eligibility and grant: a lone eligible port wins, a contended grant follows the pointer.
    always_comb begin
        elig0     = req0_if.valid & ~boot_mode_i;
        elig1     = req1_if.valid;
        both_elig = elig0 & elig1;
        win_any   = elig0 | elig1;
        win_id    = both_elig ? ptr_q : elig1;
    end

    // A full FIFO can still take a request when the head pops in the same cycle.
    always_comb begin
        full         = (cnt_q == CW'(OUTSTANDING_P));
        empty        = (cnt_q == '0);
        tag_full_eff = full & ~mem_if.rvalid;
        head         = tags_q[rd_q];
        accept       = mem_if.valid & mem_if.ready;
        push         = accept;
        pop          = mem_if.rvalid & ~empty;
    end

    // Forward the winner's request; fields read zero when nobody is asking.
    always_comb begin
        mem_if.valid   = win_any & ~tag_full_eff;
        mem_if.wen     = 1'b0;
        mem_if.byte_nw = 1'b0;
        mem_if.addr    = '0;
        mem_if.wdata   = '0;
        if (win_any) begin
            if (win_id) begin
                mem_if.wen     = req1_if.wen;
                mem_if.byte_nw = req1_if.byte_nw;
                mem_if.addr    = req1_if.addr;
                mem_if.wdata   = req1_if.wdata;
            end else begin
                mem_if.wen     = req0_if.wen;
                mem_if.byte_nw = req0_if.byte_nw;
                mem_if.addr    = req0_if.addr;
                mem_if.wdata   = req0_if.wdata;
            end
        end
    end

    // Yumi to the winner and response steering by the FIFO head tag, both same-cycle.
    always_comb begin
        req0_if.ready  = accept & ~win_id;
        req1_if.ready  = accept &  win_id;
        req0_if.rvalid = pop & ~head;
        req1_if.rvalid = pop &  head;
        req0_if.rdata  = mem_if.rdata;
        req1_if.rdata  = mem_if.rdata;
    end

    // Next-state for pointer, FIFO indices/count and the sticky error.
    always_comb begin
        ptr_d   = accept ? ~win_id : ptr_q;
        wr_d    = push ? wr_q + PW'(1) : wr_q;
        rd_d    = pop  ? rd_q + PW'(1) : rd_q;
        cnt_d   = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        error_d = error_q | (mem_if.rvalid & empty);
    end

    // State registers; reset empties the FIFO and prefers port 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            tags_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            if (push) tags_q[wr_q] <= win_id;
        end
    end

    assign error_o = error_q;

`ifdef DMEM_PORT_ARB_STATS_EN
    logic [31:0] g0_q, g0_d, g1_q, g1_d, cf_q, cf_d;

    // Saturating grant and contention counters.
    always_comb begin
        g0_d = g0_q;
        g1_d = g1_q;
        cf_d = cf_q;
        if (req0_if.ready && g0_q != '1) g0_d = g0_q + 32'd1;
        if (req1_if.ready && g1_q != '1) g1_d = g1_q + 32'd1;
        if (both_elig && accept && cf_q != '1) cf_d = cf_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            g0_q <= '0;
            g1_q <= '0;
            cf_q <= '0;
        end else begin
            g0_q <= g0_d;
            g1_q <= g1_d;
            cf_q <= cf_d;
        end
    end

    assign grant0_cnt_o   = g0_q;
    assign grant1_cnt_o   = g1_q;
    assign conflict_cnt_o = cf_q;
`else
    assign grant0_cnt_o   = '0;
    assign grant1_cnt_o   = '0;
    assign conflict_cnt_o = '0;
`endif
endmodule
